// File: rtl/npu_image_loader.sv
// npu_image_loader: upstream feeder for npu_top.
// Accepts an 8x8 stream of PIX_W-bit grayscale pixels over valid/ready, thresholds each pixel
// to one bit (1 iff pix_data >= THRESH), packs the 64 bits LSB-first into image, pulses start
// and holds image stable until npu_done. Framing errors pulse err_frame; frame_cnt counts
// launched images.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   pix_valid/pix_ready  pixel handshake; pix_data and pix_last sampled on transfer
//   image, start         packed image and its one-cycle "new image" strobe
//   npu_done, busy       NPU completion input and image-in-use status
//   err_frame            one-cycle pulse on a framing error
//   frame_cnt            number of images launched (wraps)
//
// Build option: define NPU_LDR_DBUF_EN to keep filling while the NPU computes (adds state PEND).

module npu_image_loader #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_last,
   output logic             pix_ready,
   output logic [63:0]      image,
   output logic             start,
   input  logic             npu_done,
   output logic             busy,
   output logic             err_frame,
   output logic [15:0]      frame_cnt
);

   // Compare at a width that holds both operands so an oversized THRESH never truncates.
   localparam int unsigned CmpW = (PIX_W > 32) ? PIX_W : 32;

`ifdef NPU_LDR_DBUF_EN
   typedef enum logic [1:0] {StFill, StLaunch, StWait, StPend} state_e;
`else
   typedef enum logic [1:0] {StFill, StLaunch, StWait} state_e;
`endif

   state_e      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [63:0] fbuf_q, fbuf_d;
   logic [63:0] image_q, image_d;
   logic        ready_q, ready_d;
   logic        start_q, start_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic xfer;
   logic pix_bit;
   logic at_end;
   logic frame_done;

   always_comb begin
      xfer       = pix_valid & ready_q;
      pix_bit    = CmpW'(pix_data) >= CmpW'(THRESH);
      at_end     = (idx_q == 6'd63);
      frame_done = 1'b0;

      state_d = state_q;
      idx_d   = idx_q;
      fbuf_d  = fbuf_q;
      image_d = image_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;

      // The 64th pixel always completes a frame; pix_last only decides whether it was framed
      // correctly. An early pix_last drops the partial frame by rewinding the index.
      if (xfer) begin
         fbuf_d[idx_q] = pix_bit;
         err_d         = pix_last ^ at_end;
         if (at_end) begin
            idx_d      = 6'd0;
            frame_done = 1'b1;
         end else if (pix_last) begin
            idx_d = 6'd0;
         end else begin
            idx_d = idx_q + 6'd1;
         end
      end

      case (state_q)
         StFill: begin
            if (frame_done) state_d = StLaunch;
         end
         StLaunch: begin
            image_d = fbuf_q;
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = StWait;
         end
         StWait: begin
`ifdef NPU_LDR_DBUF_EN
            if (npu_done) begin
               busy_d  = 1'b0;
               state_d = frame_done ? StLaunch : StFill;
            end else if (frame_done) begin
               state_d = StPend;
            end
`else
            if (npu_done) begin
               busy_d  = 1'b0;
               state_d = StFill;
            end
`endif
         end
`ifdef NPU_LDR_DBUF_EN
         StPend: begin
            if (npu_done) begin
               busy_d  = 1'b0;
               state_d = StLaunch;
            end
         end
`endif
         default: state_d = StFill;
      endcase

      // Ready is registered from the next state so it drops in the cycle after the 64th pixel.
`ifdef NPU_LDR_DBUF_EN
      ready_d = (state_d == StFill) || (state_d == StWait);
`else
      ready_d = (state_d == StFill);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFill;
         idx_q   <= 6'd0;
         fbuf_q  <= 64'h0;
         image_q <= 64'h0;
         ready_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fbuf_q  <= fbuf_d;
         image_q <= image_d;
         ready_q <= ready_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pix_ready = ready_q;
   assign image     = image_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign err_frame = err_q;
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_npu_image_loader.sv
module tb_npu_image_loader;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned THRESH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic [63:0] image;
   logic        start;
   logic        npu_done;
   logic        busy;
   logic        err_frame;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   npu_image_loader #(
      .PIX_W  (PIX_W),
      .THRESH (THRESH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_last  (pix_last),
      .pix_ready (pix_ready),
      .image     (image),
      .start     (start),
      .npu_done  (npu_done),
      .busy      (busy),
      .err_frame (err_frame),
      .frame_cnt (frame_cnt)
   );

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   int xfers = 0;
   logic [7:0] pix_buf [64];

   typedef struct {
      logic [63:0] bits;
      logic [7:0]  hi;
      logic [7:0]  lo;
      int          last_at;
      bit          exp_launch;
      bit          exp_err;
      logic [63:0] exp_img;
   } vec_t;

   vec_t tbl [6];

   // Count accepted pixels independently of the driver.
   always @(posedge clk) begin
      if (!rst && pix_valid && pix_ready) xfers <= xfers + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: each pixel independently compared with the threshold, pixel i at bit i.
   function automatic logic [63:0] ref_image();
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = (32'(pix_buf[i]) >= THRESH);
      return r;
   endfunction

   task automatic send_px(input logic [7:0] d, input bit last);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = last;
      for (int k = 0; k < 300; k++) begin
         if (pix_ready === 1'b1) begin
            tick();
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            return;
         end
         tick();
      end
      checks++;
      errors++;
      $display("FAIL send_px: pix_ready stayed low for 300 cycles");
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_pix_ready", pix_ready, 0);
      check("rst_image", image, 64'h0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_err_frame", err_frame, 0);
      check("rst_frame_cnt", frame_cnt, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      check_reset_values();
      rst     = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic release_npu(input int lat);
      repeat (lat) tick();
      npu_done = 1'b1;
      tick();
      npu_done = 1'b0;
      check("busy_after_done", busy, 0);
      check("ready_after_done", pix_ready, 1);
   endtask

   // Streams pix_buf[0..n-1]; lat < 0 leaves the loader waiting for npu_done.
   task automatic run_frame(input int n, input int last_at, input int max_gap, input bit exp_launch,
                            input bit exp_err, input logic [63:0] exp_img, input int lat);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(max_gap, 0)) tick();
         send_px(pix_buf[i], (i == last_at));
      end
      check("err_frame_pulse", err_frame, exp_err);
      check("start_early", start, 0);
      check("ready_after_last", pix_ready, !exp_launch);
      tick();
      check("err_frame_clear", err_frame, 0);
      check("start", start, exp_launch);
      if (exp_launch) begin
         exp_cnt++;
         check("image", image, exp_img);
         check("busy_at_start", busy, 1);
`ifdef NPU_LDR_DBUF_EN
         check("ready_in_wait", pix_ready, 1);
`else
         check("ready_in_wait", pix_ready, 0);
`endif
      end
      check("frame_cnt", frame_cnt, 64'(16'(exp_cnt)));
      tick();
      check("start_one_cycle", start, 0);
      if (exp_launch && lat >= 0) release_npu(lat);
   endtask

   task automatic apply_vec(input vec_t v, input int lat);
      int n;
      for (int i = 0; i < 64; i++) pix_buf[i] = v.bits[i] ? v.hi : v.lo;
      n = (v.last_at >= 0 && v.last_at < 63) ? v.last_at + 1 : 64;
      run_frame(n, v.last_at, 1, v.exp_launch, v.exp_err, v.exp_img, lat);
   endtask

   initial begin
      logic [63:0] img_a;
      logic [63:0] img_b;
      int x0;
      int mode;
      int last_at;
      int n;

      tbl[0] = '{64'h1C3030303C3E3C0C, 8'd16, 8'd0, 63, 1'b1, 1'b0, 64'h1C3030303C3E3C0C};
      tbl[1] = '{64'hF0F00F0F12345678, 8'd8, 8'd7, 63, 1'b1, 1'b0, 64'hF0F00F0F12345678};
      tbl[2] = '{64'h00000000000000FF, 8'd255, 8'd7, 63, 1'b1, 1'b0, 64'h00000000000000FF};
      tbl[3] = '{64'hFFFF0000FFFF0000, 8'd200, 8'd3, -1, 1'b1, 1'b1, 64'hFFFF0000FFFF0000};
      tbl[4] = '{64'hFFFFFFFFFFFFFFFF, 8'd9, 8'd0, 9, 1'b0, 1'b1, 64'h0};
      tbl[5] = '{64'hA5A55A5A0F0FF0F0, 8'd8, 8'd7, 63, 1'b1, 1'b0, 64'hA5A55A5A0F0FF0F0};

      pix_valid = 1'b0;
      pix_data  = 8'd0;
      pix_last  = 1'b0;
      npu_done  = 1'b0;

      do_reset();

      // npu_done is held high in FILL here and must be ignored.
      npu_done = 1'b1;
      tick();
      npu_done = 1'b0;
      check("done_ignored_in_fill", busy, 0);

      for (int t = 0; t < 6; t++) apply_vec(tbl[t], 3);

      // Threshold edge: 7 is below, 8 and 255 are at/above.
      for (int i = 0; i < 64; i++) pix_buf[i] = 8'd7;
      pix_buf[0]  = 8'd8;
      pix_buf[63] = 8'd255;
      run_frame(64, 63, 0, 1'b1, 1'b0, 64'h8000000000000001, 2);

      // Random frames with random framing, gaps and NPU latency.
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 64; i++) pix_buf[i] = 8'($urandom_range(15, 0));
         mode = $urandom_range(3, 0);
         if (mode == 0) last_at = $urandom_range(62, 0);
         else if (mode == 1) last_at = -1;
         else last_at = 63;
         n = (last_at >= 0 && last_at < 63) ? last_at + 1 : 64;
         run_frame(n, last_at, 2, (n == 64), (last_at != 63), ref_image(),
                   $urandom_range(10, 0));
      end

`ifndef NPU_LDR_DBUF_EN
      // Backpressure: pixels offered throughout WAIT must not be taken.
      do_reset();
      for (int i = 0; i < 64; i++) pix_buf[i] = 8'($urandom);
      run_frame(64, 63, 3, 1'b1, 1'b0, ref_image(), -1);
      x0        = xfers;
      pix_valid = 1'b1;
      pix_data  = 8'd200;
      repeat (18) tick();
      check("no_xfer_in_wait", 64'(xfers), 64'(x0));
      check("ready_low_in_wait", pix_ready, 0);
      pix_valid = 1'b0;
      release_npu(0);
      for (int i = 0; i < 64; i++) pix_buf[i] = 8'($urandom);
      run_frame(64, 63, 3, 1'b1, 1'b0, ref_image(), 1);
      check("frame_cnt_two", frame_cnt, 16'd2);
`endif

      // Reset mid-frame, then an early-last frame, then a clean one counting from 1.
      for (int i = 0; i < 30; i++) send_px(8'd255, 1'b0);
      rst = 1'b1;
      tick();
      check_reset_values();
      rst     = 1'b0;
      exp_cnt = 0;
      apply_vec(tbl[4], 3);
      apply_vec(tbl[0], 3);
      check("cnt_after_reset", frame_cnt, 16'd1);

`ifdef NPU_LDR_DBUF_EN
      // Frame B fills during A's WAIT, parks in PEND, launches one cycle after npu_done.
      do_reset();
      apply_vec(tbl[0], -1);
      img_a = tbl[0].exp_img;
      for (int i = 0; i < 64; i++) pix_buf[i] = 8'($urandom_range(15, 0));
      img_b = ref_image();
      for (int i = 0; i < 64; i++) send_px(pix_buf[i], (i == 63));
      check("pend_ready", pix_ready, 0);
      check("pend_busy", busy, 1);
      check("pend_image", image, img_a);
      repeat (4) begin
         tick();
         check("pend_hold_image", image, img_a);
         check("pend_no_start", start, 0);
      end
      npu_done = 1'b1;
      tick();
      npu_done = 1'b0;
      check("launch_no_start", start, 0);
      check("launch_image_a", image, img_a);
      tick();
      check("start_b", start, 1);
      check("image_b", image, img_b);
      check("frame_cnt_b", frame_cnt, 16'd2);
      tick();
      release_npu(1);
`else
      img_a = 64'h0;
      img_b = 64'h0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
